// File: rtl/fir_interp.sv
// Shared sample-width definition used by the filter datapath.
package globals_pkg;
  localparam int DATA_SIZE = 32;
endpackage

// Polyphase FIR interpolator: each input sample yields INTERPOLATION filtered output samples.
// Latency: first output M+1 cycles after the read cycle (M = NUM_TAPS/INTERPOLATION), each later phase M+1 after the previous one.
// Backpressure: waits in S_WRITE while y_out_full, holding accumulator and phase; reads only when the input FIFO is not empty.
module fir_interp
  import globals_pkg::*;
#(
  parameter int NUM_TAPS      = 32,  // must be an integer multiple of INTERPOLATION
  parameter int INTERPOLATION = 4,
  parameter int QUANT_BITS    = 10,
  // Tap i sits at bits [i*DATA_SIZE +: DATA_SIZE]
  parameter logic [NUM_TAPS*DATA_SIZE-1:0] COEFFICIENTS = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] x_in_dout,
  input  logic                        x_in_empty,
  output logic                        x_in_rd_en,
  input  logic                        y_out_full,
  output logic                        y_out_wr_en,
  output logic signed [DATA_SIZE-1:0] y_out_din
);

  localparam int M     = NUM_TAPS / INTERPOLATION;
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam int PH_W  = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic signed [2*DATA_SIZE-1:0] RND = (2*DATA_SIZE)'(1) << (QUANT_BITS - 1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state, next_state;

  logic signed [DATA_SIZE-1:0] dly [M];
  logic signed [DATA_SIZE-1:0] acc;
  logic [PH_W-1:0]             phase;
  logic [IDX_W-1:0]            mac_idx;

  logic signed [DATA_SIZE-1:0]   coef_mem [NUM_TAPS];
  logic [TAP_W-1:0]              tap_idx;
  logic signed [DATA_SIZE-1:0]   d_sel;
  logic signed [DATA_SIZE-1:0]   c_sel;
  logic signed [2*DATA_SIZE-1:0] d_ext;
  logic signed [2*DATA_SIZE-1:0] c_ext;
  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [2*DATA_SIZE-1:0] prod_rnd;
  logic signed [DATA_SIZE-1:0]   mult_term;
  logic                          mac_last;
  logic                          phase_last;

  // Unpack the flat coefficient vector into an indexable table
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_coef
    assign coef_mem[i] = COEFFICIENTS[i*DATA_SIZE +: DATA_SIZE];
  end

  // Polyphase tap for delay slot k and phase p is COEFFICIENTS[k*L + p]
  assign tap_idx    = TAP_W'(int'(mac_idx) * INTERPOLATION + int'(phase));
  assign d_sel      = dly[mac_idx];
  assign c_sel      = coef_mem[tap_idx];
  assign mac_last   = (mac_idx == IDX_W'(M - 1));
  assign phase_last = (phase == PH_W'(INTERPOLATION - 1));

  // Full-width signed product, round half up, arithmetic shift, keep low DATA_SIZE bits
  assign d_ext     = {{DATA_SIZE{d_sel[DATA_SIZE-1]}}, d_sel};
  assign c_ext     = {{DATA_SIZE{c_sel[DATA_SIZE-1]}}, c_sel};
  assign prod      = d_ext * c_ext;
  assign prod_rnd  = prod + RND;
  assign mult_term = DATA_SIZE'(prod_rnd >>> QUANT_BITS);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_READ;
    end else begin
      state <= next_state;
    end
  end

  // Next state and FIFO strobes; strobes are gated by reset so nothing moves while it is held
  always_comb begin
    next_state  = S_READ;
    x_in_rd_en  = 1'b0;
    y_out_wr_en = 1'b0;
    y_out_din   = '0;
    case (state)
      S_READ: begin
        next_state = S_READ;
        if (!x_in_empty && reset) begin
          x_in_rd_en = 1'b1;
          next_state = S_MAC;
        end
      end
      S_MAC: begin
        next_state = mac_last ? S_WRITE : S_MAC;
      end
      S_WRITE: begin
        next_state = S_WRITE;
        if (!y_out_full && reset) begin
          y_out_wr_en = 1'b1;
          y_out_din   = acc;
          next_state  = phase_last ? S_READ : S_MAC;
        end
      end
      default: begin
        next_state = S_READ;
      end
    endcase
  end

  // Delay line, accumulator, phase and MAC index updates driven by the FSM strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < M; k++) dly[k] <= '0;
      acc     <= '0;
      phase   <= '0;
      mac_idx <= '0;
    end else begin
      case (state)
        S_READ: begin
          if (x_in_rd_en) begin
            for (int k = M - 1; k > 0; k--) dly[k] <= dly[k-1];
            dly[0]  <= x_in_dout;
            acc     <= '0;
            phase   <= '0;
            mac_idx <= '0;
          end
        end
        S_MAC: begin
          acc     <= acc + mult_term;
          mac_idx <= mac_last ? '0 : mac_idx + IDX_W'(1);
        end
        S_WRITE: begin
          if (y_out_wr_en && !phase_last) begin
            phase <= phase + PH_W'(1);
            acc   <= '0;
          end
        end
        default: begin
          mac_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_interp.sv
// Scoreboard bench for fir_interp: directed vectors with hand-computed expected outputs.
// Two instances: ramp taps (1..32) for impulse/rounding/flow-control/reset, flat 0.25 taps for DC.
// Stimulus pushes expectations into queues; negedge monitors pop and compare on every write.
module tb_fir_interp;

  localparam int DW = globals_pkg::DATA_SIZE;
  localparam int NT = 32;

  function automatic logic [NT*DW-1:0] make_ramp();
    logic [NT*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) r[i*DW +: DW] = DW'(i + 1);
    return r;
  endfunction

  localparam logic [NT*DW-1:0] RAMP_COEF = make_ramp();
  localparam logic [NT*DW-1:0] DC_COEF   = {NT{32'd256}};

  logic clock;
  logic reset;
  logic signed [DW-1:0] x_in_dout, x2_dout, y_out_din, y2_din;
  logic x_in_empty, x2_empty, x_in_rd_en, x2_rd_en;
  logic y_out_full, y2_full, y_out_wr_en, y2_wr_en;

  logic signed [DW-1:0] xq[$], xq2[$], expq[$], expq2[$];
  logic signed [DW-1:0] e1, e2;
  logic rd_seen, rd_seen2, last_rd;
  int n_checks = 0;
  int n_fail   = 0;

  fir_interp #(.NUM_TAPS(NT), .INTERPOLATION(4), .QUANT_BITS(10), .COEFFICIENTS(RAMP_COEF)) u_imp (
    .clock(clock), .reset(reset),
    .x_in_dout(x_in_dout), .x_in_empty(x_in_empty), .x_in_rd_en(x_in_rd_en),
    .y_out_full(y_out_full), .y_out_wr_en(y_out_wr_en), .y_out_din(y_out_din)
  );

  fir_interp #(.NUM_TAPS(NT), .INTERPOLATION(4), .QUANT_BITS(10), .COEFFICIENTS(DC_COEF)) u_dc (
    .clock(clock), .reset(reset),
    .x_in_dout(x2_dout), .x_in_empty(x2_empty), .x_in_rd_en(x2_rd_en),
    .y_out_full(y2_full), .y_out_wr_en(y2_wr_en), .y_out_din(y2_din)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic signed [DW-1:0] act, input logic signed [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Input FIFO models: head and empty flag follow the queues
  task automatic refresh();
    x_in_empty = (xq.size() == 0);
    x_in_dout  = (xq.size() != 0) ? xq[0] : '0;
    x2_empty   = (xq2.size() == 0);
    x2_dout    = (xq2.size() != 0) ? xq2[0] : '0;
  endtask

  // Advance one cycle; drive #1 after the rising edge and retire any popped heads
  task automatic tick();
    @(posedge clock);
    #1;
    last_rd = rd_seen;
    if (rd_seen && xq.size() != 0) void'(xq.pop_front());
    if (rd_seen2 && xq2.size() != 0) void'(xq2.pop_front());
    rd_seen  = 1'b0;
    rd_seen2 = 1'b0;
    refresh();
  endtask

  task automatic push_x(input logic signed [DW-1:0] v);
    xq.push_back(v);
    refresh();
  endtask

  task automatic expect4(input int a, input int b, input int c, input int d);
    expq.push_back(DW'(a));
    expq.push_back(DW'(b));
    expq.push_back(DW'(c));
    expq.push_back(DW'(d));
  endtask

  task automatic wait_rd(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_rd && n < budget);
    check("wait_read_timeout", DW'(last_rd), 1);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((expq.size() != 0 || xq.size() != 0 || expq2.size() != 0 || xq2.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check(name, DW'(expq.size() + xq.size() + expq2.size() + xq2.size()), 0);
  endtask

  // Monitors: protocol rules every cycle, scoreboard pop on every write
  always @(negedge clock) begin
    rd_seen  = x_in_rd_en;
    rd_seen2 = x2_rd_en;
    if (reset) begin
      check("imp_rd_while_empty", DW'(x_in_rd_en & x_in_empty), 0);
      check("imp_wr_while_full", DW'(y_out_wr_en & y_out_full), 0);
      check("imp_rd_and_wr", DW'(x_in_rd_en & y_out_wr_en), 0);
      if (!y_out_wr_en) check("imp_din_idle", y_out_din, 0);
      check("dc_rd_and_wr", DW'(x2_rd_en & y2_wr_en), 0);
      if (!y2_wr_en) check("dc_din_idle", y2_din, 0);
    end
    if (y_out_wr_en) begin
      if (expq.size() == 0) begin
        check("imp_unexpected_write", y_out_din, 32'hDEAD_BEEF);
      end else begin
        e1 = expq.pop_front();
        check("imp_output", y_out_din, e1);
      end
    end
    if (y2_wr_en) begin
      if (expq2.size() == 0) begin
        check("dc_unexpected_write", y2_din, 32'hDEAD_BEEF);
      end else begin
        e2 = expq2.pop_front();
        check("dc_output", y2_din, e2);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    y_out_full = 1'b0;
    y2_full    = 1'b0;
    rd_seen    = 1'b0;
    rd_seen2   = 1'b0;
    last_rd    = 1'b0;
    refresh();

    // Reset state: all strobes and data low, even with a sample waiting
    push_x(7);
    repeat (2) @(negedge clock);
    check("rst_rd_en", DW'(x_in_rd_en), 0);
    check("rst_wr_en", DW'(y_out_wr_en), 0);
    check("rst_din", y_out_din, 0);
    check("rst_dc_rd_en", DW'(x2_rd_en), 0);
    check("rst_dc_din", y2_din, 0);
    xq.delete();
    tick();
    reset = 1'b1;

    // Impulse: 1024 (=1.0) then zeros walks out taps 1..32, then silence
    push_x(1024);
    repeat (8) push_x(0);
    for (int i = 0; i < 32; i++) expq.push_back(DW'(i + 1));
    expect4(0, 0, 0, 0);
    drain("impulse_drain", 1000);

    // Rounding + backpressure: 512*tap{1,2,3,4} -> 1,1,2,2; then delayed by one slot, taps 5..8 -> 3,3,4,4
    y_out_full = 1'b1;
    push_x(512);
    push_x(0);
    expect4(1, 1, 2, 2);
    expect4(3, 3, 4, 4);
    wait_rd(20);
    // 8 MAC cycles then 10 stalled S_WRITE cycles with a sample still waiting
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      check("bp_no_read", DW'(x_in_rd_en), 0);
      check("bp_no_write", DW'(y_out_wr_en), 0);
      tick();
    end
    check("bp_held_count", DW'(expq.size()), 8);
    y_out_full = 1'b0;
    @(negedge clock);
    check("bp_write_after_release", DW'(y_out_wr_en), 1);
    drain("bp_drain", 1000);

    // Starvation: 50 idle cycles, then an immediate read on the first non-empty cycle
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      check("starve_no_read", DW'(x_in_rd_en), 0);
      check("starve_no_write", DW'(y_out_wr_en), 0);
      tick();
    end
    // d = [1024, 0, 512]: taps p+1 and p+9 -> 1+5, 2+5, 3+6, 4+6
    push_x(1024);
    expect4(6, 7, 9, 10);
    @(negedge clock);
    check("starve_resume_read", DW'(x_in_rd_en), 1);
    drain("starve_drain", 1000);

    // Reset mid-MAC: d = [2048, 1024, 0, 512], phase 0 = 2 + 5 + 7 = 14; phases 1..3 are discarded
    push_x(2048);
    push_x(-513);
    expq.push_back(DW'(14));
    wait_rd(20);
    repeat (11) tick();
    check("pre_reset_phase0_written", DW'(expq.size()), 0);
    reset = 1'b0;
    #1;
    check("midmac_rst_rd_en", DW'(x_in_rd_en), 0);
    check("midmac_rst_wr_en", DW'(y_out_wr_en), 0);
    check("midmac_rst_din", y_out_din, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_hold_rd_en", DW'(x_in_rd_en), 0);
      check("rst_hold_wr_en", DW'(y_out_wr_en), 0);
      tick();
    end
    reset = 1'b1;
    // Cleared delay line: -513*tap{1,2,3,4} -> -1,-1,-2,-2; then one slot later taps 5..8 -> -3,-3,-4,-4
    expect4(-1, -1, -2, -2);
    push_x(0);
    expect4(-3, -3, -4, -4);
    @(negedge clock);
    check("post_reset_first_read", DW'(x_in_rd_en), 1);
    drain("post_reset_drain", 1000);

    // DC: 1024 * 0.25 = 256 per filled slot, settling at 8*256 = 2048
    for (int n = 1; n <= 20; n++) begin
      xq2.push_back(DW'(1024));
      for (int p = 0; p < 4; p++) expq2.push_back(DW'(((n < 8) ? n : 8) * 256));
    end
    refresh();
    drain("dc_drain", 2000);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
